// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 8-digit hex display scanner.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // Position of the most significant non-zero nibble; 0 when the value is zero.
  function automatic digit_idx_t msd_index(input logic [DATA_W-1:0] v);
    digit_idx_t m;
    m = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[k*NIBBLE_W +: NIBBLE_W] != '0) m = digit_idx_t'(k);
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick is high in the terminal count cycle.
module scan_prescaler #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan.sv
// 8-digit multiplexed display scanner with double-buffered, frame-aligned data loads.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZ_BLANK_EN.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  blank,
  output logic [NIBBLE_W-1:0]   bcd,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  logic tick;
  logic boundary;

  digit_idx_t                idx_q, idx_d;
  logic [DATA_W-1:0]         active_q, active_d;
  logic [DATA_W-1:0]         pend_data_q, pend_data_d;
  logic                      pending_q, pending_d;
  logic [NIBBLE_W-1:0]       bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_done_q;
  logic                      blank_q;

  logic [NIBBLE_W-1:0]       nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     sel_n;
  logic [NUM_DIGITS-1:0]     lz_mask;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign boundary = tick && (idx_q == LAST_DIGIT);

  always_comb begin
    idx_d       = tick ? idx_q + digit_idx_t'(1) : idx_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_data_d = pend_data_q;
    // Promotion looks at pending as it stood before this cycle, so a load
    // accepted in the boundary cycle waits for the following frame.
    if (boundary && pending_q) begin
      active_d  = pend_data_q;
      pending_d = 1'b0;
    end
    if (data_valid && !pending_q) begin
      pending_d   = 1'b1;
      pend_data_d = data_in;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]   = active_d[gi*NIBBLE_W +: NIBBLE_W];
      assign sel_n[gi] = (idx_d != digit_idx_t'(gi));
`ifdef DISP_SCAN_LZ_BLANK_EN
      assign lz_mask[gi] = (digit_idx_t'(gi) > msd_index(active_d));
`else
      assign lz_mask[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    bcd_d = tick ? nib[idx_d] : bcd_q;
    // Anodes refresh on a tick, and also right after blank falls so the
    // current digit reappears without waiting for the next slot.
    if (blank)                an_d = AN_OFF;
    else if (tick || blank_q) an_d = sel_n | lz_mask;
    else                      an_d = an_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      active_q     <= '0;
      pend_data_q  <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= '0;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
      blank_q      <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_data_q  <= pend_data_d;
      pending_q    <= pending_d;
      bcd_q        <= bcd_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
      blank_q      <= blank;
    end
  end

  assign data_ready = ~pending_q;
  assign bcd        = bcd_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan.sv
// Randomized/directed bench for disp_scan (PRESCALE=4) against a cycle-count reference model.
module tb_disp_scan;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        blank;
  logic [3:0]  bcd;
  logic [7:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset release plus the two data buffers.
  int          m_n;
  logic [31:0] m_active;
  logic [31:0] m_pdata;
  logic        m_pend;
  logic [3:0]  e_bcd;
  logic [7:0]  e_an;
  logic        e_fd;

  disp_scan #(.PRESCALE(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .blank     (blank),
    .bcd       (bcd),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_active = '0; m_pdata = '0; m_pend = 1'b0;
    e_bcd = '0; e_an = 8'hFF; e_fd = 1'b0;
  endtask

  function automatic bit digit_shown(input int d, input logic [31:0] act);
    int msd;
    msd = 0;
`ifdef DISP_SCAN_LZ_BLANK_EN
    for (int k = 0; k < 8; k++) if (act[4*k +: 4] != 4'h0) msd = k;
`else
    msd = 7;
`endif
    return d <= msd;
  endfunction

  task automatic check_all();
    check("an", {24'h0, an}, {24'h0, e_an});
    check("bcd", {28'h0, bcd}, {28'h0, e_bcd});
    check("data_ready", {31'h0, data_ready}, {31'h0, ~m_pend});
    check("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic b);
    bit boundary;
    bit ready_before;
    int idx;
    data_valid = v; data_in = d; blank = b;
    @(posedge clk);
    m_n++;
    idx          = (m_n / P) % 8;
    boundary     = (m_n % (P * 8)) == 0;
    ready_before = !m_pend;
    if (boundary && m_pend) begin
      m_active = m_pdata;
      m_pend   = 1'b0;
    end
    if (v && ready_before) begin
      m_pend  = 1'b1;
      m_pdata = d;
    end
    e_fd  = boundary;
    e_bcd = (m_n >= P) ? m_active[4*idx +: 4] : 4'h0;
    if (b || m_n < P || !digit_shown(idx, m_active)) e_an = 8'hFF;
    else                                             e_an = ~(8'h01 << idx);
    #1;
    $display("edge %0d v=%0b d=%h blank=%0b -> an=%h bcd=%h rdy=%0b fd=%0b",
             m_n, v, d, b, an, bcd, data_ready, frame_done);
    check_all();
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; data_valid = 1'b0; data_in = '0; blank = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Idle through the first tick, then load and try a second load while pending.
    repeat (6) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h12345678, 1'b0);
    repeat (3) step(1'b1, 32'hDEADBEEF, 1'b0);
    repeat (70) step(1'b0, 32'h0, 1'b0);

    // Blank mid-slot, then release.
    step(1'b0, 32'h0, 1'b0);
    repeat (6) step(1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 7) == 0);

    // Leading-zero patterns (full display in the default build).
    guard = 0;
    while (m_pend && guard < 100) begin step(1'b0, 32'h0, 1'b0); guard++; end
    step(1'b1, 32'h000000A5, 1'b0);
    repeat (70) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h00000000, 1'b0);
    repeat (70) step(1'b0, 32'h0, 1'b0);

    // Mid-frame reset with a load pending at idx 3.
    guard = 0;
    while (!((m_n % (P * 8)) == 1 && !m_pend) && guard < 200) begin
      step(1'b0, 32'h0, 1'b0); guard++;
    end
    check("align_guard", guard < 200, 1);
    step(1'b1, 32'hCAFEF00D, 1'b0);
    guard = 0;
    while (((m_n / P) % 8) != 3 && guard < 40) begin step(1'b0, 32'h0, 1'b0); guard++; end
    check("idx3_guard", guard < 40, 1);
    check("pending_at_idx3", {31'h0, data_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    repeat (70) step(1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter: PRESCALE, default 100000, clk cycles each digit is held (legal range 2..2^20).
REQ-002 Port: clk  input  1  system clock; all state advances on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: data_in  input  32  eight hex nibbles to display; nibble k maps to digit k, and digit 0 is the rightmost.
REQ-005 Port: data_valid  input  1  load request for data_in.
REQ-006 Port: data_ready  output  1  high when a load can be accepted.
REQ-007 Port: blank  input  1  forces all anodes off while high.
REQ-008 Port: bcd  output  4  nibble of the currently selected digit, which drives the downstream 7-segment decoder.
REQ-009 Port: an  output  8  active-low one-hot anode select.
REQ-010 Port: frame_done  output  1  one-cycle pulse when digit 7's slot ends.

Function
REQ-011 The prescaler counter shall count 0..PRESCALE-1, wrap to 0, and assert the internal tick in its terminal cycle.
REQ-012 The digit index shall advance on tick, sequencing 0,1,...,7, and wrap 7->0.
REQ-013 bcd and an shall be registered and load the values for the next digit index in the tick cycle, so they change on the same edge as the index.
REQ-014 an shall equal ~(1<<idx) unless a blank condition holds, in which case an shall be 8'hFF; bcd shall be active[4*idx+3:4*idx] regardless of blanking.
REQ-015 A load shall be accepted when data_valid && data_ready, at which point data_in is captured into the pending register, pending is set, and data_ready drops on the next cycle.
REQ-016 data_ready shall equal ~pending, and data_valid shall be ignored while data_ready is low.
REQ-017 In the frame boundary cycle (tick with idx==7), if pending was set before that cycle, the pending register shall be copied to active and pending cleared, so the display never tears mid-frame.
REQ-018 A load accepted in a boundary cycle shall not be promoted in that cycle, but at the next boundary.
REQ-019 frame_done shall pulse for exactly one cycle, registered, on the edge after each boundary cycle.
REQ-020 blank shall take effect on the next clk edge without waiting for a tick, and scanning, loading and promotion shall continue while blanked.

Reset
REQ-021 While rst_n is low, the block shall hold: prescaler=0, idx=0, active=0, pending=0, an=8'hFF, bcd=4'h0, frame_done=0, data_ready=1.
REQ-022 Reset asserted mid-frame shall discard both active and pending contents immediately.
REQ-023 After rst_n deasserts, the first tick shall occur PRESCALE cycles later.

Configuration
REQ-024 When the macro DISP_SCAN_LZ_BLANK_EN is defined, any digit above the most significant non-zero nibble of active shall be blanked (an bit high), digit 0 shall always be shown, and active==0 shall show a single "0".
REQ-025 When DISP_SCAN_LZ_BLANK_EN is undefined, all eight digits shall be shown, and there shall be no extra logic.

Structure
REQ-026 The shared package disp_pkg shall hold NUM_DIGITS=8, NIBBLE_W=4, AN_OFF=8'hFF, and the digit-index type.
REQ-027 The tick generator shall be a sub-module named scan_prescaler with ports clk, rst_n and tick, and parameter PRESCALE.
REQ-028 The 7-segment decoder shall be instantiated externally, not inside disp_scan.

Verification (PRESCALE=4)
REQ-029 Reset test: hold rst_n=0 -> an=FF, bcd=0, data_ready=1, frame_done=0; release -> first an change occurs 4 cycles later.
REQ-030 Load test: load 32'h12345678 -> data_ready=0; after the next boundary, digit 0 shows bcd=8/an=FE, digit 7 shows bcd=1/an=7F, each slot lasts 4 cycles, and frame_done pulses every 32 cycles.
REQ-031 Back-pressure test: a second data_valid of 32'hDEADBEEF while pending -> it is ignored, 12345678 is displayed, and data_ready returns to 1 after the boundary.
REQ-032 Blank test: blank=1 mid-slot -> an=FF on the next edge while the bcd sequence continues; blank=0 -> the current digit reappears on the next edge.
REQ-033 Leading-zero test (DISP_SCAN_LZ_BLANK_EN defined): 32'h000000A5 -> only an=FE and an=FD are ever active; 32'h0 -> only digit 0 is lit, with bcd=0.
REQ-034 Mid-frame reset test: pulse rst_n low at idx=3 with pending set -> an=FF immediately, and after release the display shows 0 with pending=0.
